iob_regfile_responder: RTL

IOb-native responder (slave) end of the CSR bus: a bank of N_REGS 32-bit software registers with byte-strobe writes, registered read responses and optional programmable wait states. It sits behind an IOb-native initiator (CPU, bus split or bench driver). It exposes the register contents to peripheral logic through a flat bus, and is the generic target that CSR-mapped peripherals reuse.

---
 rtl/iob_regfile_resp_pkg.sv | 18 +
 rtl/iob_regfile_resp_waitgen.sv | 52 +++++
 rtl/iob_regfile_responder.sv | 95 +++++++++
 3 files changed

// File: rtl/iob_regfile_resp_pkg.sv
// Shared types and constants for the IOb register-file responder.
// The FSM state type is used only when IOB_REGFILE_RESP_WAIT_EN is defined.
package iob_regfile_resp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DATA_W_C  = 32;
    localparam int NBYTES    = DATA_W_C / 8;
    localparam int REG_IDX_W = 3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_regfile_resp_waitgen.sv
// Wait-state generator: holds off acceptance for wait_i cycles per request.
// Compiled only with IOB_REGFILE_RESP_WAIT_EN defined.
`ifdef IOB_REGFILE_RESP_WAIT_EN
module iob_regfile_resp_waitgen
    import iob_regfile_resp_pkg::*;
#(
    parameter int WAIT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cke_i,
    input  logic              valid_i,
    input  logic [WAIT_W-1:0] wait_i,
    output logic              ready_o
);

    state_t            r_state;
    logic [WAIT_W-1:0] r_cnt;
    logic              w_idle_go;
    logic              w_wait_go;

    assign w_idle_go = (r_state == IDLE) && (wait_i == '0);
    assign w_wait_go = (r_state == WAIT) && (r_cnt == '0);
    assign ready_o   = rst_n_i & cke_i & valid_i & (w_idle_go | w_wait_go);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (cke_i) begin
            unique case (r_state)
                IDLE: begin
                    if (valid_i && (wait_i != '0)) begin
                        r_cnt   <= wait_i - 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // A dropped request abandons the wait without side effects
                    if (!valid_i || (r_cnt == '0)) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`endif

// File: rtl/iob_regfile_responder.sv
// IOb-native register-file responder with byte-strobe writes and registered reads.
// Optional wait states are enabled by defining IOB_REGFILE_RESP_WAIT_EN.
module iob_regfile_responder
    import iob_regfile_resp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
`ifdef IOB_REGFILE_RESP_WAIT_EN
    parameter int WAIT_W = 4,
`endif
    parameter int N_REGS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     cke_i,
    input  logic                     iob_valid_i,
    input  logic [ADDR_W-3:0]        iob_addr_i,
    input  logic [DATA_W-1:0]        iob_wdata_i,
    input  logic [DATA_W/8-1:0]      iob_wstrb_i,
    output logic                     iob_ready_o,
    output logic                     iob_rvalid_o,
    output logic [DATA_W-1:0]        iob_rdata_o,
`ifdef IOB_REGFILE_RESP_WAIT_EN
    input  logic [WAIT_W-1:0]        wait_i,
`endif
    output logic [N_REGS*DATA_W-1:0] regs_o
);

    localparam int AW = ADDR_W - 2;

    logic [DATA_W-1:0] r_regs [N_REGS];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic [DATA_W-1:0] w_rdsel;
    logic              w_wr;
    logic              w_rd;

`ifdef IOB_REGFILE_RESP_WAIT_EN
    iob_regfile_resp_waitgen #(
        .WAIT_W (WAIT_W)
    ) u_waitgen (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .cke_i   (cke_i),
        .valid_i (iob_valid_i),
        .wait_i  (wait_i),
        .ready_o (iob_ready_o)
    );
`else
    assign iob_ready_o = iob_valid_i & cke_i & rst_n_i;
`endif

    assign w_wr = iob_ready_o & (|iob_wstrb_i);
    assign w_rd = iob_ready_o & ~(|iob_wstrb_i);

    // Addresses beyond N_REGS match no entry: writes drop, reads give zero
    always_comb begin
        w_rdsel = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (iob_addr_i == AW'(k)) begin
                w_rdsel = r_regs[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < N_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else if (cke_i) begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdsel;
            end
            for (int k = 0; k < N_REGS; k++) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (w_wr && (iob_addr_i == AW'(k)) && iob_wstrb_i[b]) begin
                        r_regs[k][8*b +: 8] <= iob_wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    assign iob_rvalid_o = r_rvalid;
    assign iob_rdata_o  = r_rdata;

    for (genvar k = 0; k < N_REGS; k++) begin : g_flat
        assign regs_o[DATA_W*k +: DATA_W] = r_regs[k];
    end

endmodule
